// File: rtl/fpu_pkg.sv
// Shared FP32 divider constants, operand classification and payload types.
package fpu_pkg;

    localparam int unsigned D_WIDTH   = 32;
    localparam int unsigned E_WIDTH   = 8;
    localparam int unsigned M_WIDTH   = 23;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned ITER      = 25;
    localparam int unsigned Q_WIDTH   = M_WIDTH + 2;
    localparam int unsigned X_WIDTH   = E_WIDTH + 2;
    localparam int unsigned CNT_WIDTH = $clog2(ITER);
    localparam int unsigned EXP_MAX   = (1 << E_WIDTH) - 1;

    localparam logic [D_WIDTH-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [D_WIDTH-1:0] POS_INF  = 32'h7F80_0000;
    localparam logic [D_WIDTH-1:0] MAN_MASK = 32'h007F_FFFF;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } div_state_e;

    typedef struct packed {
        logic                sign;
        logic [E_WIDTH-1:0]  exp;
        logic [M_WIDTH-1:0]  man;
    } fp32_t;

    typedef struct packed {
        logic dbz;
        logic invalid;
        logic overflow;
        logic underflow;
    } fpu_flags_t;

    // Denormals collapse into ZERO; all-ones exponent splits on the mantissa.
    function automatic fp_class_e fp_classify(input logic [D_WIDTH-1:0] w);
        fp_class_e cls;
        if ((w & POS_INF) == '0) begin
            cls = ZERO;
        end else if ((w & POS_INF) == POS_INF) begin
            cls = ((w & MAN_MASK) == '0) ? INF : NAN;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fpu_div_mantissa_core.sv
// Iterative radix-2 restoring divider on {1,mantissa} operands, one quotient bit per cycle.
module fpu_div_mantissa_core
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [M_WIDTH-1:0] dividend_man,
    input  logic [M_WIDTH-1:0] divisor_man,
    output logic               done,
    output logic [Q_WIDTH-1:0] quotient
);

    logic [Q_WIDTH-1:0]   rem_q, rem_d;
    logic [Q_WIDTH-1:0]   div_q, div_d;
    logic [Q_WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [Q_WIDTH-1:0]   rem_sel;
    logic                 ge;

    always_comb begin
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ge      = (rem_q >= div_q);
        rem_sel = ge ? (rem_q - div_q) : rem_q;

        if (start) begin
            rem_d  = {2'b01, dividend_man};
            div_d  = {2'b01, divisor_man};
            quo_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Quotient bits enter at the LSB so the first bit ends up at the MSB.
            quo_d = {quo_q[Q_WIDTH-2:0], ge};
            rem_d = rem_sel << 1;
            if (cnt_q == CNT_WIDTH'(ITER - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/fpu_divider.sv
// Sequential FP32 divider: handshake FSM, exponent path, special cases and truncating pack.
module fpu_divider
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] dividend_in,
    input  logic [D_WIDTH-1:0] divisor_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] quotient_out,
    output logic               dbz_out,
    output logic               invalid_out,
    output logic               overflow_out,
    output logic               underflow_out
);

    div_state_e         state_q, state_d;
    logic               sign_q, sign_d;
    logic [X_WIDTH-1:0] exp_q, exp_d;
    logic               spec_q, spec_d;
    logic [D_WIDTH-1:0] spec_res_q, spec_res_d;
    fpu_flags_t         spec_flags_q, spec_flags_d;
    logic [D_WIDTH-1:0] quotient_q, quotient_d;
    fpu_flags_t         flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    fp32_t              op_a, op_b;
    fp_class_e          cls_a, cls_b;
    logic               accept_c;
    logic               sign_c;
    logic [X_WIDTH-1:0] exp_c;
    logic [X_WIDTH-1:0] norm_exp;
    logic [M_WIDTH-1:0] norm_man;
    logic               norm_ovf, norm_unf;
    logic               core_done;
    logic [Q_WIDTH-1:0] core_quo;

    assign op_a     = fp32_t'(dividend_in);
    assign op_b     = fp32_t'(divisor_in);
    assign cls_a    = fp_classify(dividend_in);
    assign cls_b    = fp_classify(divisor_in);
    assign accept_c = in_valid && in_ready_q;
    assign sign_c   = op_a.sign ^ op_b.sign;
    assign exp_c    = {2'b00, op_a.exp} - {2'b00, op_b.exp} + X_WIDTH'(BIAS);

    fpu_div_mantissa_core u_core (
        .clk          (clk),
        .rst          (rst),
        .start        (accept_c),
        .dividend_man (op_a.man),
        .divisor_man  (op_b.man),
        .done         (core_done),
        .quotient     (core_quo)
    );

    // A quotient below 1.0 borrows one from the exponent; the rest is truncated.
    always_comb begin
        if (core_quo[Q_WIDTH-1]) begin
            norm_man = core_quo[Q_WIDTH-2:1];
            norm_exp = exp_q;
        end else begin
            norm_man = core_quo[Q_WIDTH-3:0];
            norm_exp = exp_q - X_WIDTH'(1);
        end
        norm_ovf = !norm_exp[X_WIDTH-1] && (norm_exp >= X_WIDTH'(EXP_MAX));
        norm_unf = norm_exp[X_WIDTH-1] || (norm_exp == '0);
    end

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        spec_d       = spec_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        quotient_d   = quotient_q;
        flags_d      = flags_q;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d      = DIV;
                    sign_d       = sign_c;
                    exp_d        = exp_c;
                    spec_d       = 1'b1;
                    spec_flags_d = '0;
                    if (cls_a == NAN || cls_b == NAN ||
                        (cls_a == ZERO && cls_b == ZERO) ||
                        (cls_a == INF && cls_b == INF)) begin
                        spec_res_d           = QNAN;
                        spec_flags_d.invalid = 1'b1;
                    end else if (cls_a == NORMAL && cls_b == ZERO) begin
                        spec_res_d       = {sign_c, POS_INF[D_WIDTH-2:0]};
                        spec_flags_d.dbz = 1'b1;
                    end else if (cls_a == INF) begin
                        spec_res_d = {sign_c, POS_INF[D_WIDTH-2:0]};
                    end else if (cls_a == ZERO || cls_b == INF) begin
                        spec_res_d = {sign_c, {(D_WIDTH-1){1'b0}}};
                    end else begin
                        spec_d     = 1'b0;
                        spec_res_d = '0;
                    end
                end
            end
            DIV: begin
                if (core_done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                flags_d = '0;
                if (spec_q) begin
                    quotient_d = spec_res_q;
                    flags_d    = spec_flags_q;
                end else if (norm_ovf) begin
                    quotient_d       = {sign_q, POS_INF[D_WIDTH-2:0]};
                    flags_d.overflow = 1'b1;
                end else if (norm_unf) begin
                    quotient_d        = {sign_q, {(D_WIDTH-1){1'b0}}};
                    flags_d.underflow = 1'b1;
                end else begin
                    quotient_d = {sign_q, norm_exp[E_WIDTH-1:0], norm_man};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            quotient_q   <= '0;
            flags_q      <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            quotient_q   <= quotient_d;
            flags_q      <= flags_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign quotient_out  = quotient_q;
    assign dbz_out       = flags_q.dbz;
    assign invalid_out   = flags_q.invalid;
    assign overflow_out  = flags_q.overflow;
    assign underflow_out = flags_q.underflow;

endmodule

// File: tb/tb_fpu_divider.sv
// Self-checking bench for fpu_divider: directed cases, backpressure, mid-op reset, random ops vs model.
module tb_fpu_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend_in;
    logic [31:0] divisor_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient_out;
    logic        dbz_out;
    logic        invalid_out;
    logic        overflow_out;
    logic        underflow_out;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_divider dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .quotient_out  (quotient_out),
        .dbz_out       (dbz_out),
        .invalid_out   (invalid_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (n_tests=%0d)", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: flags {dbz, invalid, overflow, underflow} in [35:32], result in [31:0].
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic        za, zb, ia, ib, nna, nnb;
        logic [63:0] na, nb, q;
        logic [22:0] m;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 23'd0);
        ib  = (eb == 255) && (b[22:0] == 23'd0);
        nna = (ea == 255) && (a[22:0] != 23'd0);
        nnb = (eb == 255) && (b[22:0] != 23'd0);
        if (nna || nnb || (za && zb) || (ia && ib)) return {4'b0100, 32'h7FC0_0000};
        if (zb && !ia) return {4'b1000, s, 31'h7F80_0000};
        if (ia)        return {4'b0000, s, 31'h7F80_0000};
        if (za || ib)  return {4'b0000, s, 31'h0};
        na = {40'd0, 1'b1, a[22:0]};
        nb = {40'd0, 1'b1, b[22:0]};
        q  = (na << 24) / nb;
        e  = ea - eb + 127;
        if (q >= (64'd1 << 24)) begin
            m = q[23:1];
        end else begin
            m = q[22:0];
            e = e - 1;
        end
        if (e >= 255) return {4'b0010, s, 31'h7F80_0000};
        if (e <= 0)   return {4'b0001, s, 31'h0};
        return {4'b0000, s, 8'(e), m};
    endfunction

    function automatic logic [31:0] gen_op();
        int unsigned k;
        logic [31:0] w;
        k = $urandom_range(0, 19);
        w = $urandom;
        if (k < 2) begin
            w[30:23] = 8'h00;
        end else if (k < 4) begin
            w[30:23] = 8'hFF;
            w[22:0]  = 23'd0;
        end else if (k < 5) begin
            w[30:23] = 8'hFF;
            w[0]     = 1'b1;
        end else begin
            w[30:23] = 8'($urandom_range(1, 254));
        end
        return w;
    endfunction

    // One full transaction: accept, latency, result, optional stall, retire.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [3:0] exp_f, input int stall, input string tag);
        int cyc;
        int bad;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        if (!in_ready) return;
        dividend_in = a;
        divisor_in  = b;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd27);
        check({tag, " quotient"}, 64'(quotient_out), 64'(exp_q));
        check({tag, " flags"}, 64'({dbz_out, invalid_out, overflow_out, underflow_out}), 64'(exp_f));
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (quotient_out !== exp_q || {dbz_out, invalid_out, overflow_out, underflow_out} !== exp_f ||
                in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        if (stall > 0) check({tag, " stall_stable"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " retire"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    logic [31:0] dir_a [8];
    logic [31:0] dir_b [8];
    logic [31:0] dir_q [8];
    logic [3:0]  dir_f [8];

    initial begin
        logic [31:0] ra, rb;
        logic [35:0] rv;
        int          seen;

        dir_a = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000,
                  32'h0000_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000};
        dir_b = '{32'h4000_0000, 32'h4040_0000, 32'h3F00_0000, 32'h0000_0000,
                  32'h0000_0000, 32'h7F80_0000, 32'h0080_0000, 32'h7F00_0000};
        dir_q = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hC000_0000, 32'h7F80_0000,
                  32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000};
        dir_f = '{4'b0000, 4'b0000, 4'b0000, 4'b1000,
                  4'b0100, 4'b0100, 4'b0010, 4'b0001};

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state",
              64'({in_ready, out_valid, quotient_out, dbz_out, invalid_out, overflow_out, underflow_out}),
              64'({1'b1, 1'b0, 32'h0, 4'h0}));

        for (int i = 0; i < 8; i++) begin
            do_op(dir_a[i], dir_b[i], dir_q[i], dir_f[i], 0, $sformatf("dir%0d", i));
        end

        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 10, "backpressure");
        do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 4'b0000, 0, "after_bp");

        // Abort an operation in the middle of the mantissa iterations.
        dividend_in = 32'h40C0_0000;
        divisor_in  = 32'h4000_0000;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_reset",
              64'({in_ready, out_valid, quotient_out, dbz_out, invalid_out, overflow_out, underflow_out}),
              64'({1'b1, 1'b0, 32'h0, 4'h0}));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 0, "post_abort");

        for (int i = 0; i < 200; i++) begin
            ra = gen_op();
            rb = gen_op();
            rv = ref_div(ra, rb);
            do_op(ra, rb, rv[31:0], rv[35:32], (i % 17 == 0) ? 3 : 0,
                  $sformatf("rnd%0d %08h/%08h", i, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
